ks_sum_stage: RTL and testbench

Registered sum stage that sits directly downstream of the Kogge-Stone carry network (`calculateCarry`). Each beat carries operands `a` and `b` plus the carry-in-zero carry vector that the network produced for them. The stage folds in a carry-in, forms the sum word, and registers it behind a valid/ready handshake. It chains the carry-out across consecutive beats, so a wide operand can be added as a sequence of N-bit words, least-significant word first.

---
 rtl/ks_sum_stage.sv | 122 ++++++++++++
 tb/tb_ks_sum_stage.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ks_sum_stage.sv
// ks_sum_stage: registered sum stage downstream of the Kogge-Stone carry network.
// Folds a carry-in into the carry-in-zero carry vector, forms the sum word and
// registers it behind a valid/ready handshake. The carry-out is chained across
// beats so wide operands can be added LS word first.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      input handshake (in_ready = !out_valid | out_ready)
//   in_a, in_b               operand words
//   in_g                     carry vector, in_g[i] = carry out of bit i with cin=0
//   in_first, in_last        LS / MS word markers
//   out_valid / out_ready    output handshake
//   out_sum, out_cout        registered sum word and carry out
//   out_last                 registered copy of in_last
//   out_err                  beat accepted in IDLE without in_first
//   out_ovf                  signed overflow on last beat (only with KS_SUM_OVF_EN)
//
// Optional feature macro: KS_SUM_OVF_EN
module ks_sum_stage #(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_g,
  input  logic         in_first,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_cout,
  output logic         out_last,
`ifdef KS_SUM_OVF_EN
  output logic         out_ovf,
`endif
  output logic         out_err
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CHAIN = 1'b1;

  logic [0:0]   state_q;
  logic         chain_q;
  logic         acc;
  logic         cin;
  logic [N-1:0] p;
  logic [N-1:0] c;
  logic [N-1:0] sum;
  logic         cout;
  logic         pacc;
  logic         err;

  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;
  assign err      = (state_q == IDLE) && !in_first;

  // Carry into bit i is the network's carry-in-zero carry, plus cin rippling
  // through when every lower bit propagates. pacc is the running &p[i-1:0].
  always_comb begin
    p    = in_a ^ in_b;
    cin  = (in_first || state_q == IDLE) ? 1'b0 : chain_q;
    c    = '0;
    c[0] = cin;
    pacc = 1'b1;
    for (int unsigned i = 1; i < N; i++) begin
      pacc = pacc & p[i-1];
      c[i] = in_g[i-1] | (pacc & cin);
    end
    cout = in_g[N-1] | (pacc & p[N-1] & cin);
    sum  = p ^ c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
      state_q   <= IDLE;
      chain_q   <= 1'b0;
    end else begin
      if (acc) begin
        out_valid <= 1'b1;
        out_sum   <= sum;
        out_cout  <= cout;
        out_last  <= in_last;
        out_err   <= err;
        if (state_q == IDLE) begin
          if (!in_last) begin
            state_q <= CHAIN;
            chain_q <= cout;
          end
        end else begin
          if (in_last) begin
            state_q <= IDLE;
            chain_q <= 1'b0;
          end else begin
            chain_q <= cout;
          end
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef KS_SUM_OVF_EN
  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_ovf <= 1'b0;
    end else if (acc) begin
      out_ovf <= in_last & (c[N-1] ^ cout);
    end
  end
`endif

endmodule

// File: tb/tb_ks_sum_stage.sv
module tb_ks_sum_stage;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [15:0] in_g;
  logic        in_first;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_last;
  logic        out_err;
`ifdef KS_SUM_OVF_EN
  logic        out_ovf;
`endif

  int total = 0;
  int bad   = 0;

  ks_sum_stage #(.N(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_g(in_g),
    .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_last(out_last),
`ifdef KS_SUM_OVF_EN
    .out_ovf(out_ovf),
`endif
    .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Carry-in-zero carry vector, as the upstream network would produce it.
  function automatic logic [15:0] carry_vec(input logic [15:0] a, input logic [15:0] b);
    logic cc;
    logic [15:0] g;
    cc = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cc   = (a[i] & b[i]) | (cc & (a[i] ^ b[i]));
      g[i] = cc;
    end
    return g;
  endfunction

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] g,
                      input logic f, input logic l);
    int n;
    @(negedge clk);
    in_a = a; in_b = b; in_g = g; in_first = f; in_last = l; in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b1;
    in_a = 16'h1111; in_b = 16'h2222; in_g = 16'h0000; in_first = 1'b1; in_last = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || out_sum !== 16'h0000 || out_cout !== 1'b0 ||
        out_last !== 1'b0 || out_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: valid=%0b sum=%h cout=%0b last=%0b err=%0b required all 0",
               out_valid, out_sum, out_cout, out_last, out_err);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %0b required 1", in_ready);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_single();
    send(16'hFFFF, 16'h0001, 16'hFFFF, 1'b1, 1'b1);
    total++;
    if (out_valid !== 1'b1 || out_sum !== 16'h0000 || out_cout !== 1'b1 ||
        out_last !== 1'b1 || out_err !== 1'b0) begin
      bad++;
      $display("FAIL single: valid=%0b sum=%h cout=%0b last=%0b err=%0b required 1 0000 1 1 0",
               out_valid, out_sum, out_cout, out_last, out_err);
    end
  endtask

  task automatic test_two_beat();
    send(16'hFFFF, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
    total++;
    if (out_sum !== 16'h0000 || out_cout !== 1'b1 || out_last !== 1'b0 || out_err !== 1'b0) begin
      bad++;
      $display("FAIL two_beat0: sum=%h cout=%0b last=%0b err=%0b required 0000 1 0 0",
               out_sum, out_cout, out_last, out_err);
    end
    send(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1);
    total++;
    if (out_sum !== 16'h0001 || out_cout !== 1'b0 || out_last !== 1'b1 || out_err !== 1'b0) begin
      bad++;
      $display("FAIL two_beat1: sum=%h cout=%0b last=%0b err=%0b required 0001 0 1 0",
               out_sum, out_cout, out_last, out_err);
    end
    // Back in IDLE: a non-first beat is flagged and takes cin=0.
    send(16'h0001, 16'h0001, 16'h0001, 1'b0, 1'b1);
    total++;
    if (out_sum !== 16'h0002 || out_err !== 1'b1 || out_cout !== 1'b0) begin
      bad++;
      $display("FAIL two_beat_idle: sum=%h err=%0b cout=%0b required 0002 1 0",
               out_sum, out_err, out_cout);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(16'h1234, 16'h0101, 16'h0000, 1'b1, 1'b1);
    total++;
    if (out_valid !== 1'b1 || out_sum !== 16'h1335) begin
      bad++;
      $display("FAIL bp_load: valid=%0b sum=%h required 1 1335", out_valid, out_sum);
    end
    @(negedge clk);
    in_a = 16'h00F0; in_b = 16'h0F0F; in_g = 16'h0000; in_first = 1'b1; in_last = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_in_ready[%0d]: got %0b required 0", i, in_ready);
      end
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || out_sum !== 16'h1335) begin
        bad++;
        $display("FAIL bp_hold[%0d]: valid=%0b sum=%h required 1 1335", i, out_valid, out_sum);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release_ready: got %0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_sum !== 16'h0FFF) begin
      bad++;
      $display("FAIL bp_pop_push: valid=%0b sum=%h required 1 0fff", out_valid, out_sum);
    end
  endtask

  task automatic test_reset_midchain();
    send(16'hFFFF, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL midchain_reset_valid: got %0b required 0", out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    send(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1);
    total++;
    if (out_sum !== 16'h0000 || out_err !== 1'b1 || out_cout !== 1'b0 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL midchain_err: sum=%h err=%0b cout=%0b valid=%0b required 0000 1 0 1",
               out_sum, out_err, out_cout, out_valid);
    end
  endtask

`ifdef KS_SUM_OVF_EN
  task automatic test_ovf();
    send(16'h7FFF, 16'h0001, 16'h7FFF, 1'b1, 1'b1);
    total++;
    if (out_sum !== 16'h8000 || out_ovf !== 1'b1 || out_cout !== 1'b0) begin
      bad++;
      $display("FAIL ovf_pos: sum=%h ovf=%0b cout=%0b required 8000 1 0", out_sum, out_ovf, out_cout);
    end
    send(16'hFFFF, 16'h0001, 16'hFFFF, 1'b1, 1'b1);
    total++;
    if (out_sum !== 16'h0000 || out_ovf !== 1'b0 || out_cout !== 1'b1) begin
      bad++;
      $display("FAIL ovf_wrap: sum=%h ovf=%0b cout=%0b required 0000 0 1", out_sum, out_ovf, out_cout);
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [15:0] ba [128];
    logic [15:0] bb [128];
    logic        bf [128];
    logic        bl [128];
    logic [15:0] es [128];
    logic        ec [128];
    int nb, wr, rd, cyc, nw;
    logic [63:0] A, B;
    logic [64:0] full, m, ps;

    nb = 0;
    for (int op = 0; op < 20; op++) begin
      nw = $urandom_range(1, 4);
      A = {$urandom, $urandom};
      B = {$urandom, $urandom};
      if (op == 0) begin A = 64'h0000_FFFF_FFFF_FFFF; B = 64'h0000_0000_0000_0001; nw = 4; end
      if (nw < 4) begin
        A = A & ((64'd1 << (16 * nw)) - 64'd1);
        B = B & ((64'd1 << (16 * nw)) - 64'd1);
      end
      full = {1'b0, A} + {1'b0, B};
      for (int k = 0; k < nw; k++) begin
        ba[nb] = 16'(A >> (16 * k));
        bb[nb] = 16'(B >> (16 * k));
        bf[nb] = (k == 0);
        bl[nb] = (k == nw - 1);
        es[nb] = 16'(full >> (16 * k));
        m  = (65'd1 << (16 * (k + 1))) - 65'd1;
        ps = ({1'b0, A} & m) + ({1'b0, B} & m);
        ec[nb] = ps[16 * (k + 1)];
        nb++;
      end
    end

    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;

    wr = 0; rd = 0; cyc = 0;
    while (rd < nb && cyc < 3000) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      if (wr < nb) begin
        in_valid = ($urandom_range(0, 4) != 0);
        in_a = ba[wr]; in_b = bb[wr]; in_g = carry_vec(ba[wr], bb[wr]);
        in_first = bf[wr]; in_last = bl[wr];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        total++;
        if (out_sum !== es[rd] || out_cout !== ec[rd] || out_last !== bl[rd] || out_err !== 1'b0) begin
          bad++;
          $display("FAIL b2b_word[%0d]: sum=%h cout=%0b last=%0b err=%0b required %h %0b %0b 0",
                   rd, out_sum, out_cout, out_last, out_err, es[rd], ec[rd], bl[rd]);
        end
        rd++;
      end
      if (in_valid && in_ready) wr++;
      cyc++;
    end
    in_valid = 1'b0;
    if (rd < nb) begin
      total++; bad++;
      $display("FAIL b2b_timeout: popped=%0d required %0d", rd, nb);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_g = '0; in_first = 1'b0; in_last = 1'b0;
    test_reset();
    test_single();
    test_two_beat();
    test_backpressure();
    test_reset_midchain();
`ifdef KS_SUM_OVF_EN
    test_ovf();
`endif
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
